cache_arbiter: RTL and testbench

Shares the single physical-memory line port between the pipelined CPU's instruction cache (read-only) and data cache (read/write). It sits between both L1 caches and physical memory (or L2). It grants one cache-line transaction at a time, holds the winner's request stable until memory responds, and routes the response back. Arbitration alternates winners under contention so neither cache can starve the other.

---
 rtl/cache_arbiter_pkg.sv | 18 +
 rtl/cache_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_types
//   Shared types and constants for cache_arbiter.
//   - arb_state_t      : arbiter FSM states
//   - LINE_OFFSET_BITS : byte-offset bits inside one cache line (32-byte line)
// -----------------------------------------------------------------------------
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  localparam int LINE_OFFSET_BITS = 5;

endpackage : arbiter_types

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//   Shares one physical-memory line port between the instruction cache
//   (read-only) and the data cache (read/write). One line transaction is in
//   flight at a time; ties alternate winners so neither cache starves.
//
// Ports
//   clk, rst                       : clock, asynchronous active-low reset
//   i_read, i_addr                 : icache line-read request (held until i_resp)
//   i_rdata, i_resp                : icache read line and one-cycle done strobe
//   d_read, d_write, d_addr,
//   d_wdata                        : dcache request (held until d_resp)
//   d_rdata, d_resp                : dcache read line and one-cycle done strobe
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata       : memory request, held until pmem_resp
//   pmem_rdata, pmem_resp          : memory response line and done strobe
// -----------------------------------------------------------------------------
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // Clears the byte offset inside a line; memory only sees line addresses.
  localparam logic [ADDR_W-1:0] LINE_MASK =
    {{(ADDR_W-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

  // ---------------------------------------------------------------------------
  // State and request latch
  // ---------------------------------------------------------------------------
  arb_state_t        state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: dcache won the most recent grant
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic d_req;
  logic grant_d;
  logic serving;

  assign d_req = d_read | d_write;

  // On a tie the cache that did not win last time gets the port.
  assign grant_d = d_req & (~i_read | ~last_d_q);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          addr_d   = d_addr & LINE_MASK;
          // A write wins if both d_read and d_write are (illegally) high.
          write_d  = d_write;
          wdata_d  = d_wdata;
        end else if (i_read) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          addr_d   = i_addr & LINE_MASK;
          write_d  = 1'b0;
          wdata_d  = '0;
        end
      end

      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = RECOVER;
        end
      end

      // One quiet cycle so requesters can drop or change their request
      // before the next arbitration.
      RECOVER: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory side: decoded only from registered state, never from requester
  // inputs. Address and data are forced to zero outside a SERVE state so the
  // port is fully quiet in IDLE, RECOVER and reset.
  // ---------------------------------------------------------------------------
  assign serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read    = serving & ~write_q;
  assign pmem_write   = serving &  write_q;
  assign pmem_address = serving ? addr_q  : '0;
  assign pmem_wdata   = serving ? wdata_q : '0;

  // ---------------------------------------------------------------------------
  // Requester side: completion is passed through in the same cycle as
  // pmem_resp; a response outside a SERVE state produces nothing.
  // ---------------------------------------------------------------------------
  assign i_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
//   Directed bench for cache_arbiter. Inputs change 1 time unit after the
//   rising edge and outputs are sampled there too, away from the edge.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The dcache must never raise read and write together.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(d_read && d_write)) else $error("protocol violation: d_read and d_write both high");
    end
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Port completely quiet: no strobes, zero address and data.
  task automatic chk_quiet(input string tag);
    chk({tag, " pmem_read"},    LINE_W'(pmem_read),    '0);
    chk({tag, " pmem_write"},   LINE_W'(pmem_write),   '0);
    chk({tag, " pmem_address"}, LINE_W'(pmem_address), '0);
    chk({tag, " pmem_wdata"},   LINE_W'(pmem_wdata),   '0);
    chk({tag, " i_resp"},       LINE_W'(i_resp),       '0);
    chk({tag, " d_resp"},       LINE_W'(d_resp),       '0);
  endtask

  logic [LINE_W-1:0] line_a;
  logic [LINE_W-1:0] line_b;
  logic [LINE_W-1:0] line_a5;

  initial begin
    line_a  = {8{32'hDEAD_BEEF}};
    line_b  = {8{32'h0123_4567}};
    line_a5 = {32{8'hA5}};

    rst        = 1'b0;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // ---------------- reset state ----------------
    #1;
    chk_quiet("reset");
    step();
    step();
    rst = 1'b1;
    step();
    chk_quiet("post-reset idle");

    // ---------------- icache only, memory answers after 4 cycles ----------------
    i_read = 1'b1;
    i_addr = 32'h6000_0014;
    step();                                   // IDLE -> SERVE_I
    chk("icache pmem_read",    LINE_W'(pmem_read),    LINE_W'(1));
    chk("icache pmem_write",   LINE_W'(pmem_write),   '0);
    chk("icache pmem_address", LINE_W'(pmem_address), LINE_W'(32'h6000_0000));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("icache wait i_resp", LINE_W'(i_resp), '0);
      chk("icache wait d_resp", LINE_W'(d_resp), '0);
    end
    pmem_rdata = line_a;
    pmem_resp  = 1'b1;
    #1;
    chk("icache i_resp",  LINE_W'(i_resp), LINE_W'(1));
    chk("icache i_rdata", i_rdata,         line_a);
    chk("icache d_resp",  LINE_W'(d_resp), '0);
    step();                                   // SERVE_I -> RECOVER
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    #1;
    chk_quiet("icache recover");
    step();                                   // RECOVER -> IDLE
    chk_quiet("icache idle");

    // ---------------- dcache writeback, address changes during service ----------------
    d_write = 1'b1;
    d_addr  = 32'h8000_0040;
    d_wdata = line_a5;
    step();                                   // IDLE -> SERVE_D
    chk("dwrite pmem_write",   LINE_W'(pmem_write),   LINE_W'(1));
    chk("dwrite pmem_read",    LINE_W'(pmem_read),    '0);
    chk("dwrite pmem_address", LINE_W'(pmem_address), LINE_W'(32'h8000_0040));
    chk("dwrite pmem_wdata",   pmem_wdata,            line_a5);
    d_addr  = 32'h1234_5600;
    d_wdata = line_b;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("dwrite held address", LINE_W'(pmem_address), LINE_W'(32'h8000_0040));
      chk("dwrite held wdata",   pmem_wdata,            line_a5);
    end
    pmem_rdata = line_b;
    pmem_resp  = 1'b1;
    #1;
    chk("dwrite d_resp",       LINE_W'(d_resp),       LINE_W'(1));
    chk("dwrite i_resp",       LINE_W'(i_resp),       '0);
    chk("dwrite addr at resp", LINE_W'(pmem_address), LINE_W'(32'h8000_0040));
    step();                                   // SERVE_D -> RECOVER
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    #1;
    chk_quiet("dwrite recover");
    step();                                   // RECOVER -> IDLE

    // ---------------- stray response in IDLE ----------------
    pmem_resp  = 1'b1;
    pmem_rdata = line_a;
    #1;
    chk("stray i_resp", LINE_W'(i_resp), '0);
    chk("stray d_resp", LINE_W'(d_resp), '0);
    step();
    pmem_resp = 1'b0;
    #1;
    chk_quiet("stray stays idle");

    // ---------------- simultaneous after reset: D, I, D ----------------
    // The previous grant went to dcache; only a reset of last_d lets dcache
    // win the next tie.
    rst = 1'b0;
    step();
    rst    = 1'b1;
    i_read = 1'b1;
    i_addr = 32'h0000_0100;
    d_read = 1'b1;
    d_addr = 32'h0000_0200;
    step();                                   // IDLE -> SERVE_D
    chk("tie1 pmem_read",    LINE_W'(pmem_read),    LINE_W'(1));
    chk("tie1 pmem_address", LINE_W'(pmem_address), LINE_W'(32'h0000_0200));
    pmem_resp = 1'b1;
    #1;
    chk("tie1 d_resp", LINE_W'(d_resp), LINE_W'(1));
    chk("tie1 i_resp", LINE_W'(i_resp), '0);
    step();                                   // RECOVER
    pmem_resp = 1'b0;
    #1;
    chk("tie1 gap1 pmem_read", LINE_W'(pmem_read), '0);
    step();                                   // IDLE
    chk("tie1 gap2 pmem_read", LINE_W'(pmem_read), '0);
    step();                                   // SERVE_I
    chk("tie2 pmem_read",    LINE_W'(pmem_read),    LINE_W'(1));
    chk("tie2 pmem_address", LINE_W'(pmem_address), LINE_W'(32'h0000_0100));
    pmem_resp = 1'b1;
    #1;
    chk("tie2 i_resp", LINE_W'(i_resp), LINE_W'(1));
    chk("tie2 d_resp", LINE_W'(d_resp), '0);
    step();                                   // RECOVER
    pmem_resp = 1'b0;
    #1;
    chk("tie2 gap1 pmem_read", LINE_W'(pmem_read), '0);
    step();                                   // IDLE
    chk("tie2 gap2 pmem_read", LINE_W'(pmem_read), '0);
    step();                                   // SERVE_D
    chk("tie3 pmem_read",    LINE_W'(pmem_read),    LINE_W'(1));
    chk("tie3 pmem_address", LINE_W'(pmem_address), LINE_W'(32'h0000_0200));
    pmem_resp = 1'b1;
    #1;
    chk("tie3 d_resp", LINE_W'(d_resp), LINE_W'(1));
    step();                                   // RECOVER
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    d_read    = 1'b0;
    step();                                   // IDLE

    // ---------------- reset during SERVE_I ----------------
    i_read = 1'b1;
    i_addr = 32'h4000_0020;
    step();                                   // SERVE_I
    chk("rstmid pmem_read",    LINE_W'(pmem_read),    LINE_W'(1));
    chk("rstmid pmem_address", LINE_W'(pmem_address), LINE_W'(32'h4000_0020));
    #2;
    pmem_resp = 1'b1;                         // memory answers as reset hits
    rst       = 1'b0;
    #1;                                       // no clock edge yet: asynchronous
    chk_quiet("rstmid async");
    step();
    chk_quiet("rstmid held");
    pmem_resp = 1'b0;
    rst       = 1'b1;
    d_read    = 1'b1;
    d_addr    = 32'h5000_003F;
    step();                                   // tie after reset -> dcache
    chk("rstmid tie pmem_read",    LINE_W'(pmem_read),    LINE_W'(1));
    chk("rstmid tie pmem_address", LINE_W'(pmem_address), LINE_W'(32'h5000_0020));
    pmem_resp = 1'b1;
    #1;
    chk("rstmid tie d_resp", LINE_W'(d_resp), LINE_W'(1));
    chk("rstmid tie i_resp", LINE_W'(i_resp), '0);
    step();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    d_read    = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cache_arbiter
